// File: rtl/uart_rx_in_mod.sv
// UART 8N1 receiver with a 2-FF input synchroniser, mid-bit sampling and one-cycle result strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on parity_err.
module uart_rx_in_mod #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLOCK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam int CNT_W      = $clog2(BAUD_COUNT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             cnt_full;
    logic             cnt_half;
    logic             par_bad;
    logic             valid_nxt;
    logic             frame_err_nxt;
    logic             parity_err_nxt;
    logic             load_data;

    assign cnt_full = (cnt == CNT_FULL);
    assign cnt_half = (cnt == CNT_HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (cnt_half) state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (cnt_full && bit_idx == 3'd7) state_nxt = S_PARITY;
            S_PARITY: if (cnt_full) state_nxt = S_STOP;
`else
            S_DATA:   if (cnt_full && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
            // Leaving on the mid-stop sample lets a zero-gap start edge be caught.
            S_STOP:  if (cnt_full) state_nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    assign par_bad = ((^shift_reg) != parity_bit);
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        valid_nxt      = 1'b0;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        load_data      = 1'b0;
        if (state == S_STOP && cnt_full) begin
            if (rx_s) begin
                valid_nxt      = !par_bad;
                parity_err_nxt = par_bad;
                load_data      = !par_bad;
            end else begin
                frame_err_nxt  = 1'b1;
                parity_err_nxt = par_bad;
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_START: begin
                    cnt     <= cnt_half ? '0 : cnt + 1'b1;
                    bit_idx <= '0;
                end
                S_DATA: begin
                    if (cnt_full) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: cnt <= cnt_full ? '0 : cnt + 1'b1;
`endif
                S_STOP:  cnt <= cnt_full ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    // Pure datapath: contents are only consumed after a full frame has been shifted in.
    always_ff @(posedge clk) begin
        if (state == S_DATA && cnt_full) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
        end
`ifdef UART_RX_PARITY_EN
        if (state == S_PARITY && cnt_full) begin
            parity_bit <= rx_s;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid      <= valid_nxt;
            frame_err  <= frame_err_nxt;
            parity_err <= parity_err_nxt;
            if (load_data) begin
                data <= shift_reg;
            end
        end
    end
endmodule
